// File: rtl/unidade_controle_timeout_pkg.sv
// Shared definitions for the game controller: state codes (also the debug
// display value) and the default timeout length.
package unidade_controle_timeout_pkg;

  localparam int TIMEOUT_CICLOS_PADRAO = 3000;  // 3 s at 1 kHz

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERROU   = 4'hE
  } estado_t;

  function automatic logic eh_fim(input estado_t e);
    return (e == FIM_ACERTOU) || (e == FIM_ERROU) || (e == FIM_TIMEOUT);
  endfunction

endpackage

// File: rtl/unidade_controle_timeout_contador.sv
// Saturating timeout counter: synchronous clear, count enable, flags the
// last allowed cycle (MODULO-1) and never wraps.
module contador_timeout #(
  parameter int MODULO = 3000,
  localparam int W = (MODULO > 1) ? $clog2(MODULO) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim_contagem
);

  localparam logic [W-1:0] TERMINAL = W'(MODULO - 1);

  logic [W-1:0] valor_q, valor_d;

  always_comb begin
    valor_d = valor_q;
    if (zera) begin
      valor_d = '0;
    end else if (conta && (valor_q != TERMINAL)) begin
      valor_d = valor_q + W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign fim_contagem = (valor_q == TERMINAL);

endmodule

// File: rtl/unidade_controle_timeout.sv
// Control unit for the memory game: Moore FSM sequencing play register,
// sequence counter and a per-play response timeout.
module unidade_controle_timeout
  import unidade_controle_timeout_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic [3:0] db_estado,
  output logic       db_timeout,
  output logic       db_estado_espera
);

  estado_t estado_q, estado_d;
  logic    timeout_fim;
  logic    timeout_zera;
  logic    timeout_conta;

  // The wait budget restarts on every new game and every new play.
  assign timeout_zera  = (estado_q == PREPARACAO) || (estado_q == PROXIMO);
  assign timeout_conta = (estado_q == ESPERA);

  contador_timeout #(
    .MODULO(TIMEOUT_CICLOS)
  ) u_contador_timeout (
    .clock       (clock),
    .reset       (reset),
    .zera        (timeout_zera),
    .conta       (timeout_conta),
    .fim_contagem(timeout_fim)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIAL;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:     if (iniciar) estado_d = PREPARACAO;
      PREPARACAO:  estado_d = ESPERA;
      // A play arriving on the last allowed cycle still counts.
      ESPERA: begin
        if (jogada) begin
          estado_d = REGISTRA;
        end else if (timeout_fim) begin
          estado_d = FIM_TIMEOUT;
        end
      end
      REGISTRA:    estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual) begin
          estado_d = FIM_ERROU;
        end else if (fim) begin
          estado_d = FIM_ACERTOU;
        end else begin
          estado_d = PROXIMO;
        end
      end
      PROXIMO:     estado_d = ESPERA;
      FIM_ACERTOU,
      FIM_ERROU,
      FIM_TIMEOUT: if (iniciar) estado_d = PREPARACAO;
      default:     estado_d = INICIAL;
    endcase
  end

  always_comb begin
    zeraC            = 1'b0;
    contaC           = 1'b0;
    zeraR            = 1'b0;
    registraR        = 1'b0;
    acertou          = 1'b0;
    errou            = 1'b0;
    db_timeout       = 1'b0;
    db_estado_espera = 1'b0;
    pronto           = eh_fim(estado_q);
    db_estado        = estado_q;
    case (estado_q)
      PREPARACAO: begin
        zeraC = 1'b1;
        zeraR = 1'b1;
      end
      ESPERA:      db_estado_espera = 1'b1;
      REGISTRA:    registraR = 1'b1;
      PROXIMO:     contaC = 1'b1;
      FIM_ACERTOU: acertou = 1'b1;
      FIM_ERROU:   errou = 1'b1;
      FIM_TIMEOUT: begin
        errou      = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_timeout.sv
// Bench for unidade_controle_timeout: vector table, directed corner cases
// and randomized play against a behavioural game model.
module tb_unidade_controle_timeout;

  localparam int T = 3000;

  localparam int S_INI  = 'h0;
  localparam int S_PREP = 'h1;
  localparam int S_ESP  = 'h2;
  localparam int S_REG  = 'h4;
  localparam int S_CMP  = 'h5;
  localparam int S_PROX = 'h6;
  localparam int S_ACE  = 'hA;
  localparam int S_TMO  = 'hD;
  localparam int S_ERR  = 'hE;

  logic       clock, reset, iniciar, jogada, igual, fim;
  logic       zeraC, contaC, zeraR, registraR, acertou, errou, pronto;
  logic [3:0] db_estado;
  logic       db_timeout, db_estado_espera;

  unidade_controle_timeout #(.TIMEOUT_CICLOS(T)) dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar         (iniciar),
    .jogada          (jogada),
    .igual           (igual),
    .fim             (fim),
    .zeraC           (zeraC),
    .contaC          (contaC),
    .zeraR           (zeraR),
    .registraR       (registraR),
    .acertou         (acertou),
    .errou           (errou),
    .pronto          (pronto),
    .db_estado       (db_estado),
    .db_timeout      (db_timeout),
    .db_estado_espera(db_estado_espera)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int n_contaC = 0;
  int m_state = S_INI;
  int m_wait = 0;

  typedef struct {
    logic       ini, jog, ig, fi;
    logic [3:0] est;
    logic       zera, pronto, errou;
  } vetor_t;

  vetor_t tab[18];

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nome, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] saida_atual();
    return {db_estado, zeraC, contaC, zeraR, registraR, acertou, errou, pronto,
            db_timeout, db_estado_espera};
  endfunction

  // Expected flags as a function of where the game is.
  function automatic logic [12:0] exp_out(input int s);
    logic acabou;
    acabou = (s == S_ACE) || (s == S_ERR) || (s == S_TMO);
    return {4'(s), s == S_PREP, s == S_PROX, s == S_PREP, s == S_REG, s == S_ACE,
            (s == S_ERR) || (s == S_TMO), acabou, s == S_TMO, s == S_ESP};
  endfunction

  task automatic model_reset();
    m_state = S_INI;
    m_wait  = 0;
  endtask

  // m_wait = cycles already spent waiting for the current play.
  task automatic model_step(input logic ini, input logic jog, input logic ig, input logic fi);
    case (m_state)
      S_INI:  if (ini) m_state = S_PREP;
      S_PREP: begin m_state = S_ESP; m_wait = 0; end
      S_ESP: begin
        if (jog) m_state = S_REG;
        else if (m_wait == T - 1) m_state = S_TMO;
        else m_wait++;
      end
      S_REG:  m_state = S_CMP;
      S_CMP:  m_state = !ig ? S_ERR : (fi ? S_ACE : S_PROX);
      S_PROX: begin m_state = S_ESP; m_wait = 0; end
      default: if (ini) m_state = S_PREP;
    endcase
  endtask

  task automatic tick(input logic ini, input logic jog, input logic ig, input logic fi);
    iniciar = ini;
    jogada  = jog;
    igual   = ig;
    fim     = fi;
    @(posedge clock);
    model_step(ini, jog, ig, fi);
    #1;
    if (contaC) n_contaC++;
    check("saidas", 32'(saida_atual()), 32'(exp_out(m_state)));
  endtask

  // Called 1 time unit after a rising edge; reset released before the next edge.
  task automatic pulso_reset();
    #3;
    reset = 1'b1;
    #1;
    check("reset_assincrono", 32'(saida_atual()), 32'h0);
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0};
    tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0};
    tab[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0};
    tab[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0};
    tab[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0};
    tab[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0};
    tab[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0};
    tab[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 1'b0, 1'b1, 1'b1};
    tab[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 1'b0, 1'b1, 1'b1};
    tab[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0};
    tab[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0};
    tab[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0};
    tab[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0};
    tab[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0};
    tab[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0};
    tab[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0};
    tab[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0};
    tab[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; iniciar = 1'b1; jogada = 1'b0; igual = 1'b0; fim = 1'b0;
    #1;
    check("reset_inicial", 32'(saida_atual()), 32'h0);
    #20;
    check("reset_mantido", 32'(saida_atual()), 32'h0);
    reset = 1'b0;
    model_reset();

    // Start, wrong play, restart, one correct step, final correct play.
    for (int i = 0; i < 18; i++) begin
      tick(tab[i].ini, tab[i].jog, tab[i].ig, tab[i].fi);
      check($sformatf("tab%0d_estado", i), 32'(db_estado), 32'(tab[i].est));
      check($sformatf("tab%0d_zera", i), 32'({zeraC, zeraR}), {30'd0, tab[i].zera, tab[i].zera});
      check($sformatf("tab%0d_pronto", i), 32'(pronto), 32'(tab[i].pronto));
      check($sformatf("tab%0d_errou", i), 32'(errou), 32'(tab[i].errou));
    end

    // Four plays, one every 10 cycles, last one ends the sequence.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_contaC = 0;
    for (int i = 0; i < 4; i++) begin
      repeat (9) tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1, i == 3);
      tick(1'b0, 1'b0, 1'b1, i == 3);
      if (i < 3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("quatro_jogadas_contaC", 32'(n_contaC), 32'd3);
    check("quatro_jogadas_estado", 32'(db_estado), 32'hA);
    check("quatro_jogadas_acertou", 32'(acertou), 32'd1);

    // Full timeout: FIM_TIMEOUT exactly T cycles after entering ESPERA.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (T - 1) tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("timeout_ainda_espera", 32'(db_estado), 32'h2);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("timeout_estado", 32'(db_estado), 32'hD);
    check("timeout_flags", 32'({errou, pronto, db_timeout, acertou}), 32'b1110);

    // Restart from timeout; counter must start from zero again.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("reinicio_estado", 32'(db_estado), 32'h1);
    check("reinicio_flags", 32'({errou, pronto, db_timeout, acertou}), 32'b0000);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (T - 1) tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("reinicio_contador_zerado", 32'(db_estado), 32'h2);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("jogada_vence_timeout", 32'(db_estado), 32'h4);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("em_comparacao", 32'(db_estado), 32'h5);
    pulso_reset();
    check("reset_em_comparacao", 32'(db_estado), 32'h0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("pos_reset_inicial", 32'(db_estado), 32'h0);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulso_reset();
      end else begin
        tick($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
